// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-access stage load/store unit:
// funct3 size/sign encodings, FSM state type and access-size decode.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Any funct3 that is not a byte or half encoding is handled as a word.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Valid/ready data-memory bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [DATA_W-1:0] dmem_req_wdata;
  logic [3:0]        dmem_req_wstrb;
  logic              dmem_rsp_valid;
  logic [DATA_W-1:0] dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_formatter.sv
// Load data formatter: picks the addressed byte/half out of the read word
// and sign- or zero-extends it; word (and undefined funct3) passes through.
module load_formatter
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_offset,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane extraction followed by extension chosen from funct3.
  always_comb begin
    w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage load/store unit. Issues one data-memory request at a
// time, stalls the pipeline while it is outstanding and formats load data
// for the MEM/WB register.
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses
// (misalign_err pulse, no bus request, ram_data cleared); without it the
// address is silently force-aligned and misalign_err stays 0.
//
// state | meaning
// IDLE  | no access in flight; stall only while a mem op is presented
// REQ   | request driven on the bus, fields held until accepted
// WAIT  | load accepted, waiting for the read-data pulse
// DONE  | access complete; stall released so MEM/WB captures once
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  mem_stage_lsu_if.master   dmem,
  output logic [DATA_W-1:0] ram_data,
  output logic              mem_wb_wren,
  output logic              pipeline_stall,
  output logic              misalign_err
);

  lsu_state_t        r_state;
  lsu_state_t        w_next_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_offset;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_misalign;

  logic              w_mem_op;
  logic              w_we;
  lsu_size_t         w_size;
  logic [1:0]        w_offset;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic              w_trap;
  logic              w_stall;
  logic [DATA_W-1:0] w_fmt;

  assign w_mem_op = ex_valid & (ex_mem_read | ex_mem_write);
  // Read wins when both read and write are flagged.
  assign w_we     = ex_mem_write & ~ex_mem_read;
  assign w_size   = f3_size(ex_funct3);

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = ((w_size == SZ_H) && ex_addr[0]) ||
                        ((w_size == SZ_W) && (ex_addr[1:0] != 2'b00));
  assign w_trap = w_mem_op & w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  // Lane offset with the size's alignment forced; for trapped builds every
  // access reaching the bus is already aligned, so this is a no-op there.
  always_comb begin
    w_offset = 2'b00;
    w_wstrb  = 4'b1111;
    w_wdata  = ex_store_data;
    case (w_size)
      SZ_B: begin
        w_offset = ex_addr[1:0];
        w_wstrb  = 4'b0001 << ex_addr[1:0];
        w_wdata  = {4{ex_store_data[7:0]}};
      end
      SZ_H: begin
        w_offset = {ex_addr[1], 1'b0};
        w_wstrb  = 4'b0011 << {ex_addr[1], 1'b0};
        w_wdata  = {2{ex_store_data[15:0]}};
      end
      default: begin
        w_offset = 2'b00;
        w_wstrb  = 4'b1111;
        w_wdata  = ex_store_data;
      end
    endcase
  end

  load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
    .i_rdata  (dmem.dmem_rsp_rdata),
    .i_funct3 (r_funct3),
    .i_offset (r_offset),
    .o_data   (w_fmt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next state and pipeline stall.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_mem_op;
        if (w_trap)        w_next_state = DONE;
        else if (w_mem_op) w_next_state = REQ;
      end
      REQ: begin
        w_stall = 1'b1;
        if (dmem.dmem_req_ready) w_next_state = r_we ? DONE : WAIT;
      end
      WAIT: begin
        w_stall = 1'b1;
        if (dmem.dmem_rsp_valid) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request capture on issue, load result capture on response, trap flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_offset   <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= 4'b0000;
      r_ram_data <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if ((r_state == IDLE) && w_mem_op) begin
        if (w_trap) begin
          r_misalign <= 1'b1;
          r_ram_data <= '0;
        end else begin
          r_we     <= w_we;
          r_funct3 <= ex_funct3;
          r_offset <= w_offset;
          r_addr   <= {ex_addr[ADDR_W-1:2], 2'b00};
          r_wdata  <= w_wdata;
          r_wstrb  <= w_wstrb;
        end
      end
      if ((r_state == WAIT) && dmem.dmem_rsp_valid) r_ram_data <= w_fmt;
    end
  end

  assign dmem.dmem_req_valid = (r_state == REQ);
  assign dmem.dmem_req_we    = r_we;
  assign dmem.dmem_req_addr  = r_addr;
  assign dmem.dmem_req_wdata = r_wdata;
  assign dmem.dmem_req_wstrb = r_wstrb;

  assign ram_data       = r_ram_data;
  assign pipeline_stall = w_stall;
  assign mem_wb_wren    = ~w_stall;
  assign misalign_err   = r_misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed scenarios plus randomized ops checked
// against a behavioural model of the memory stage.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data;
  logic [31:0] ram_data;
  logic        mem_wb_wren, pipeline_stall, misalign_err;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_funct3      (ex_funct3),
    .ex_addr        (ex_addr),
    .ex_store_data  (ex_store_data),
    .dmem           (bus),
    .ram_data       (ram_data),
    .mem_wb_wren    (mem_wb_wren),
    .pipeline_stall (pipeline_stall),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Observations from one instruction's pass through the stage.
  int          o_cyc, o_stall, o_acc, o_reqcyc, o_unstable, o_mis;
  bit          o_timeout;
  logic [31:0] o_addr, o_wdata, o_ram;
  logic [3:0]  o_wstrb;
  logic        o_we;
  logic [31:0] exp_ram;

  // ---------------- reference model ----------------
  function automatic int sz_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int off_of(input logic [2:0] f3, input logic [31:0] a);
    int s, lo;
    s  = sz_of(f3);
    lo = int'(a % 4);
    if (s == 1) return lo;
    if (s == 2) return (lo / 2) * 2;
    return 0;
  endfunction

  function automatic bit misal(input logic [2:0] f3, input logic [31:0] a);
    int s;
    s = sz_of(f3);
    return (s == 2 && (a % 2) != 0) || (s == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    int s, o;
    logic [31:0] v;
    s = sz_of(f3);
    o = off_of(f3, a);
    v = w;
    if (s == 1) begin
      v = (w >> (8 * o)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (s == 2) begin
      v = (w >> (16 * (o / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [31:0] a);
    int s, o;
    s = sz_of(f3);
    o = off_of(f3, a);
    if (s == 1) return 4'(1 << o);
    if (s == 2) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] d);
    int s;
    s = sz_of(f3);
    if (s == 1) return (d & 32'hFF) * 32'h01010101;
    if (s == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  // ---------------- stimulus driver (observes only, no checking) ----------
  // Called at a falling edge; returns at a falling edge after the cycle in
  // which mem_wb_wren let the instruction leave the stage.
  task automatic run_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rw,
                        input int rdy_lat, input int rsp_lat, input bit junk);
    int rq, wcnt;
    bit waiting, done;
    rq = 0; wcnt = 0; waiting = 0; done = 0;
    o_cyc = 0; o_stall = 0; o_acc = 0; o_reqcyc = 0; o_unstable = 0; o_mis = 0; o_timeout = 0;
    o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 1'b0; o_ram = '0;
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3;
    ex_addr = a; ex_store_data = sd;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.dmem_req_ready = (rq >= rdy_lat);
      if (waiting) begin
        bus.dmem_rsp_valid = (wcnt == rsp_lat);
        bus.dmem_rsp_rdata = (wcnt == rsp_lat) ? rw : $urandom;
      end else begin
        bus.dmem_rsp_valid = junk && ($urandom_range(0, 1) == 1);
        bus.dmem_rsp_rdata = $urandom;
      end
      #1;
      if (misalign_err) o_mis++;
      if (pipeline_stall) o_stall++;
      if (bus.dmem_req_valid) begin
        if (rq == 0) begin
          o_addr = bus.dmem_req_addr; o_wdata = bus.dmem_req_wdata;
          o_wstrb = bus.dmem_req_wstrb; o_we = bus.dmem_req_we;
        end else if (o_addr !== bus.dmem_req_addr || o_wdata !== bus.dmem_req_wdata ||
                     o_wstrb !== bus.dmem_req_wstrb || o_we !== bus.dmem_req_we) begin
          o_unstable++;
        end
        rq++;
        o_reqcyc++;
        if (bus.dmem_req_ready) begin
          o_acc++;
          if (!bus.dmem_req_we) begin waiting = 1; wcnt = 0; end
        end
      end else if (waiting) begin
        if (bus.dmem_rsp_valid) waiting = 0;
        else wcnt++;
      end
      if (mem_wb_wren) begin
        done = 1; o_cyc = c + 1; o_ram = ram_data;
      end
      @(negedge clk);
    end
    if (!done) o_timeout = 1;
    ex_valid = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pipeline_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", pipeline_stall); end
    checks++; if (mem_wb_wren !== 1'b1) begin errors++; $display("FAIL reset_wren got %b want 1", mem_wb_wren); end
    checks++; if (bus.dmem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", bus.dmem_req_valid); end
    checks++; if (bus.dmem_req_we !== 1'b0) begin errors++; $display("FAIL reset_req_we got %b want 0", bus.dmem_req_we); end
    checks++; if (bus.dmem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 0", bus.dmem_req_addr); end
    checks++; if (bus.dmem_req_wdata !== 32'h0) begin errors++; $display("FAIL reset_req_wdata got %h want 0", bus.dmem_req_wdata); end
    checks++; if (bus.dmem_req_wstrb !== 4'h0) begin errors++; $display("FAIL reset_req_wstrb got %h want 0", bus.dmem_req_wstrb); end
    checks++; if (ram_data !== 32'h0) begin errors++; $display("FAIL reset_ram_data got %h want 0", ram_data); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
    reset_n = 1'b1;
    exp_ram = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_load_formats();
    run_op(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    checks++; if (o_timeout) begin errors++; $display("FAIL lw_timeout got 1 want 0"); end
    checks++; if (o_stall !== 3) begin errors++; $display("FAIL lw_stall_cycles got %0d want 3", o_stall); end
    checks++; if (o_cyc !== 4) begin errors++; $display("FAIL lw_latency got %0d want 4", o_cyc); end
    checks++; if (o_ram !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_ram_data got %h want deadbeef", o_ram); end
    checks++; if (o_addr !== 32'h100 || o_we !== 1'b0) begin errors++; $display("FAIL lw_req got addr %h we %b want 100 0", o_addr, o_we); end
    run_op(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 0, 1, 1);
    checks++; if (o_ram !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_ram_data got %h want ffffff80", o_ram); end
    run_op(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 1, 0, 1);
    checks++; if (o_ram !== 32'h00000080) begin errors++; $display("FAIL lbu_ram_data got %h want 00000080", o_ram); end
    run_op(1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h80AABBCC, 0, 2, 1);
    checks++; if (o_ram !== 32'h000080AA) begin errors++; $display("FAIL lhu_ram_data got %h want 000080aa", o_ram); end
    run_op(1, 1, 0, 3'b001, 32'h100, 32'h0, 32'h80AABBCC, 0, 0, 0);
    checks++; if (o_ram !== 32'hFFFFBBCC) begin errors++; $display("FAIL lh_ram_data got %h want ffffbbcc", o_ram); end
    exp_ram = 32'hFFFFBBCC;
  endtask

  task automatic test_store_backpressure();
    run_op(1, 0, 1, 3'b000, 32'h201, 32'h1234565A, 32'h0, 4, 0, 1);
    checks++; if (o_reqcyc !== 5 || o_acc !== 1) begin errors++; $display("FAIL sb_req_cycles got %0d acc %0d want 5 1", o_reqcyc, o_acc); end
    checks++; if (o_unstable !== 0) begin errors++; $display("FAIL sb_req_stable got %0d changes want 0", o_unstable); end
    checks++; if (o_addr !== 32'h200) begin errors++; $display("FAIL sb_addr got %h want 200", o_addr); end
    checks++; if (o_wstrb !== 4'b0010) begin errors++; $display("FAIL sb_wstrb got %b want 0010", o_wstrb); end
    checks++; if (o_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_wdata got %h want 5a5a5a5a", o_wdata); end
    checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sb_we got %b want 1", o_we); end
    checks++; if (o_stall !== 6 || o_cyc !== 7) begin errors++; $display("FAIL sb_stall got %0d/%0d want 6/7", o_stall, o_cyc); end
    checks++; if (o_ram !== exp_ram) begin errors++; $display("FAIL sb_ram_held got %h want %h", o_ram, exp_ram); end
  endtask

  task automatic test_back_to_back();
    run_op(1, 0, 0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 0, 1);
    checks++; if (o_cyc !== 1 || o_acc !== 0 || o_stall !== 0) begin errors++; $display("FAIL b2b_nonmem got cyc %0d acc %0d stall %0d want 1 0 0", o_cyc, o_acc, o_stall); end
    run_op(1, 1, 0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 0, 0, 0);
    checks++; if (o_cyc !== 4 || o_acc !== 1 || o_ram !== 32'h13579BDF) begin errors++; $display("FAIL b2b_lw got cyc %0d acc %0d ram %h want 4 1 13579bdf", o_cyc, o_acc, o_ram); end
    run_op(1, 0, 1, 3'b010, 32'h108, 32'hCAFEBABE, 32'h0, 0, 0, 0);
    checks++; if (o_cyc !== 3 || o_acc !== 1 || o_reqcyc !== 1) begin errors++; $display("FAIL b2b_sw got cyc %0d acc %0d req %0d want 3 1 1", o_cyc, o_acc, o_reqcyc); end
    checks++; if (o_wdata !== 32'hCAFEBABE || o_wstrb !== 4'hF || o_addr !== 32'h108) begin errors++; $display("FAIL b2b_sw_fields got %h %h %h want cafebabe f 108", o_wdata, o_wstrb, o_addr); end
    run_op(1, 0, 0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 0, 0);
    checks++; if (o_reqcyc !== 0 || o_cyc !== 1) begin errors++; $display("FAIL b2b_no_dup_req got req %0d cyc %0d want 0 1", o_reqcyc, o_cyc); end
    checks++; if (o_ram !== 32'h13579BDF) begin errors++; $display("FAIL b2b_ram_held got %h want 13579bdf", o_ram); end
    exp_ram = 32'h13579BDF;
  endtask

  task automatic test_reset_mid_op();
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
    ex_addr = 32'h300; ex_store_data = 32'h0;
    bus.dmem_req_ready = 1; bus.dmem_rsp_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (pipeline_stall !== 1'b1 || bus.dmem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_in_wait got stall %b req %b want 1 0", pipeline_stall, bus.dmem_req_valid); end
    reset_n = 0;
    ex_valid = 0;
    @(negedge clk);
    reset_n = 1;
    bus.dmem_rsp_valid = 1; bus.dmem_rsp_rdata = 32'h12345678;
    #1;
    checks++; if (pipeline_stall !== 1'b0 || bus.dmem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_idle got stall %b req %b want 0 0", pipeline_stall, bus.dmem_req_valid); end
    @(negedge clk);
    bus.dmem_rsp_valid = 0;
    #1;
    checks++; if (ram_data !== 32'h0) begin errors++; $display("FAIL rst_late_rsp ram got %h want 0", ram_data); end
    checks++; if (mem_wb_wren !== 1'b1 || bus.dmem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_after got wren %b req %b want 1 0", mem_wb_wren, bus.dmem_req_valid); end
    exp_ram = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_misalign();
    run_op(1, 1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
    checks++; if (o_mis !== 1 || o_reqcyc !== 0) begin errors++; $display("FAIL mis_lw got err %0d req %0d want 1 0", o_mis, o_reqcyc); end
    checks++; if (o_ram !== 32'h0 || o_cyc !== 2) begin errors++; $display("FAIL mis_lw got ram %h cyc %0d want 0 2", o_ram, o_cyc); end
    exp_ram = 32'h0;
`else
    checks++; if (o_addr !== 32'h100 || o_acc !== 1 || o_mis !== 0) begin errors++; $display("FAIL mis_lw got addr %h acc %0d err %0d want 100 1 0", o_addr, o_acc, o_mis); end
    checks++; if (o_ram !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_lw_ram got %h want cafef00d", o_ram); end
    run_op(1, 1, 0, 3'b001, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0, 0);
    checks++; if (o_ram !== 32'hFFFFF00D || o_addr !== 32'h100) begin errors++; $display("FAIL mis_lh got ram %h addr %h want fffff00d 100", o_ram, o_addr); end
    exp_ram = 32'hFFFFF00D;
`endif
  endtask

  task automatic test_random();
    bit trap_en;
`ifdef MISALIGN_TRAP_EN
    trap_en = 1;
`else
    trap_en = 0;
`endif
    for (int n = 0; n < 80; n++) begin
      logic v, rd, wr, mem, we, trap;
      logic [2:0] f3;
      logic [31:0] a, sd, rw;
      int rl, sl, exp_cyc;
      v  = ($urandom_range(0, 5) != 0);
      rd = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom; sd = $urandom; rw = $urandom;
      rl = $urandom_range(0, 3); sl = $urandom_range(0, 3);
      mem  = v & (rd | wr);
      we   = wr & ~rd;
      trap = trap_en && mem && misal(f3, a);
      run_op(v, rd, wr, f3, a, sd, rw, rl, sl, 1);
      if (!mem) exp_cyc = 1;
      else if (trap) exp_cyc = 2;
      else if (we) exp_cyc = rl + 3;
      else exp_cyc = rl + sl + 4;
      if (mem && !we && !trap) exp_ram = ld_val(rw, f3, a);
      if (trap) exp_ram = 32'h0;
      checks++; if (o_timeout || o_cyc !== exp_cyc) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", n, o_cyc, exp_cyc); end
      checks++; if (o_acc !== ((mem && !trap) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_accepts got %0d want %0d", n, o_acc, (mem && !trap) ? 1 : 0); end
      checks++; if (o_ram !== exp_ram) begin errors++; $display("FAIL rnd%0d_ram_data got %h want %h", n, o_ram, exp_ram); end
      checks++; if (o_mis !== (trap ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_misalign got %0d want %0d", n, o_mis, trap ? 1 : 0); end
      checks++; if (o_unstable !== 0) begin errors++; $display("FAIL rnd%0d_req_stable got %0d want 0", n, o_unstable); end
      if (o_acc > 0) begin
        checks++; if (o_addr !== {a[31:2], 2'b00} || o_we !== we) begin errors++; $display("FAIL rnd%0d_req got addr %h we %b want %h %b", n, o_addr, o_we, {a[31:2], 2'b00}, we); end
        if (we) begin
          checks++; if (o_wstrb !== st_strb(f3, a) || o_wdata !== st_data(f3, sd)) begin errors++; $display("FAIL rnd%0d_store got %b %h want %b %h", n, o_wstrb, o_wdata, st_strb(f3, a), st_data(f3, sd)); end
        end
      end
    end
  endtask

  initial begin
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 3'b000;
    ex_addr = '0; ex_store_data = '0;
    bus.dmem_req_ready = 0; bus.dmem_rsp_valid = 0; bus.dmem_rsp_rdata = '0;
    exp_ram = '0;
    test_reset();
    test_load_formats();
    test_store_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
